i2c_target_regs: RTL and testbench
==================================

// Module: i2c_target_regs
// PURPOSE
// - I2C target (responder) on the far end of the Nios-driven I2C master; lets this FPGA act as an addressable peripheral.
// - Decodes START/STOP/address/register-pointer/data from oversampled SCL/SDA.
// - Exposes a simple register-bus (write strobe, read request) to fabric logic.
// - Never drives SCL (no clock stretching); SDA is open-drain via sda_oe.
// PARAMETERS
// - DEV_ADDR      7'h42  7-bit target address matched after START
// - FILT_LEN      3      consecutive equal samples needed to accept an SCL/SDA level (glitch filter)
// PORTS
// - clk           in   1  system clock, >= 20x SCL rate
// - reset         in   1  synchronous, active-high
// - scl_in        in   1  raw SCL pin level (async)
// - sda_in        in   1  raw SDA pin level (async)
// - sda_oe        out  1  1 = pull SDA low; 0 = release
// - wr_en         out  1  one-cycle strobe: write wr_data to wr_addr
// - wr_addr       out  8  register address for write
// - wr_data       out  8  write data
// - rd_req        out  1  one-cycle strobe: fabric must present rd_data next cycle
// - rd_addr       out  8  register address for read
// - rd_data       in   8  read data, valid 1 clk after rd_req
// - busy          out  1  1 from accepted address match until STOP/repeated START
// - stop_evt      out  1  one-cycle pulse on STOP ending an addressed transaction
// BEHAVIOUR
// - Reset: sda_oe=0, wr_en=0, rd_req=0, busy=0, stop_evt=0, wr_addr=rd_addr=wr_data=0, pointer=0, state IDLE.
// - Input path: 2-FF synchroniser then FILT_LEN-sample filter; edges taken on filtered levels only.
// - START: filtered SDA 1->0 while SCL=1; STOP: SDA 0->1 while SCL=1. Both override any state.
// - Bits sampled on filtered SCL rising edge; sda_oe changes only 1 clk after filtered SCL falling edge.
// - States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_MACK.
//   IDLE --START--> ADDR (shift 8 bits MSB first).
//   ADDR: addr!=DEV_ADDR -> IDLE (no ACK, sda_oe stays 0); match -> ADDR_ACK, busy=1.
//   ADDR_ACK: drive 0 for 9th bit; R/W=0 -> PTR; R/W=1 -> rd_req at ACK start, load shift from rd_data -> RDATA.
//   PTR: 8 bits -> pointer; PTR_ACK (ACK) -> WDATA.
//   WDATA: 8 bits -> WDATA_ACK: ACK, wr_en pulse with wr_addr=pointer on 9th SCL rise; pointer update per macro.
//   RDATA: drive bit as sda_oe=~bit; after 8 bits release -> RDATA_MACK; sample master ACK:
//     ACK(0): pointer update, rd_req, reload -> RDATA; NACK(1): release, wait for STOP/START.
// - Pointer is 8 bits, wraps 8'hFF -> 8'h00.
// - Repeated START in any state -> ADDR; pointer retained (enables write-ptr-then-read).
// - STOP in any state -> IDLE, sda_oe=0 same clk as detection, busy=0, stop_evt=1 if busy was 1.
// - reset mid-byte: immediate return to reset values; no partial write issued.
// - START+STOP artefacts within filter window are rejected by FILT_LEN.
// CONFIGURATION
// - I2C_TGT_AUTOINC_EN defined: pointer +1 after every write ACK and every master read ACK.
// - Not defined: pointer fixed after PTR phase; repeated data bytes hit the same address.
// TESTING
// - Write 0x42/W, ptr 0x10, data 0xA5, STOP -> three ACKs, wr_en once with addr 0x10 data 0xA5, stop_evt pulse.
// - Address 0x43/W -> no ACK on 9th bit, sda_oe never 1, busy stays 0, no wr_en.
// - Write ptr 0x20, rSTART, 0x42/R, rd_data=0x3C then 0x5D, master ACK then NACK -> bytes 0x3C,0x5D on SDA;
//   rd_addr 0x20,0x21 with AUTOINC_EN; 0x20,0x20 without.
// - Burst write ptr 0xFE, data 0x01,0x02,0x03 (AUTOINC_EN) -> wr_addr 0xFE,0xFF,0x00.
// - STOP injected mid-data byte after 4 bits -> IDLE, sda_oe=0, no wr_en, stop_evt=1.
// - 1-clk SDA glitch while SCL high in IDLE (FILT_LEN=3) -> no START detected, state stays IDLE.

Source files
------------

// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - I2C target exposing a byte-wide register bus to fabric logic
//
// Purpose: addressable I2C responder. Oversampled SCL/SDA are synchronised and
// glitch-filtered, then START/STOP/address/pointer/data are decoded. A write
// sequence (addr/W, pointer, data...) issues wr_en strobes; a read sequence
// (addr/R) issues rd_req strobes and shifts rd_data out on SDA. SCL is never
// driven; SDA is open-drain through sda_oe.
//
// Ports:
//   clk       in   system clock, at least 20x the SCL rate
//   reset     in   synchronous, active-high
//   scl_in    in   raw SCL pin level (asynchronous)
//   sda_in    in   raw SDA pin level (asynchronous)
//   sda_oe    out  1 = pull SDA low, 0 = release
//   wr_en     out  one-cycle write strobe
//   wr_addr   out  register address for the write
//   wr_data   out  write data
//   rd_req    out  one-cycle read strobe; rd_data expected the next cycle
//   rd_addr   out  register address for the read
//   rd_data   in   read data, valid one clock after rd_req
//   busy      out  high from address match until STOP or repeated START
//   stop_evt  out  one-cycle pulse when STOP ends an addressed transaction
//
// Build option: define I2C_TGT_AUTOINC_EN to advance the register pointer after
// every acknowledged write byte and every master-acknowledged read byte.
// Without it the pointer only changes in the pointer phase.

module i2c_target_regs #(
   parameter logic [6:0] DEV_ADDR = 7'h42,
   parameter int         FILT_LEN = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic       wr_en,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       rd_req,
   output logic [7:0] rd_addr,
   input  logic [7:0] rd_data,
   output logic       busy,
   output logic       stop_evt
);

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      PTR,
      PTR_ACK,
      WDATA,
      WDATA_ACK,
      RDATA,
      RDATA_MACK
   } state_t;

   state_t state, state_next;

   // ------------------------------------------------------------------
   // Input conditioning: 2-FF synchroniser, then a level is accepted only
   // after FILT_LEN identical samples. Idle bus level is high.
   // ------------------------------------------------------------------
   logic [1:0]          scl_sync, sda_sync;
   logic [FILT_LEN-1:0] scl_hist, sda_hist;
   logic                scl_f, sda_f, scl_p, sda_p;

   always_ff @(posedge clk) begin
      if (reset) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
         scl_hist <= '1;
         sda_hist <= '1;
         scl_f    <= 1'b1;
         sda_f    <= 1'b1;
         scl_p    <= 1'b1;
         sda_p    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[0], scl_in};
         sda_sync <= {sda_sync[0], sda_in};
         scl_hist <= {scl_hist[FILT_LEN-2:0], scl_sync[1]};
         sda_hist <= {sda_hist[FILT_LEN-2:0], sda_sync[1]};
         if (scl_hist == '1)
            scl_f <= 1'b1;
         else if (scl_hist == '0)
            scl_f <= 1'b0;
         if (sda_hist == '1)
            sda_f <= 1'b1;
         else if (sda_hist == '0)
            sda_f <= 1'b0;
         scl_p <= scl_f;
         sda_p <= sda_f;
      end
   end

   logic scl_rise, scl_fall, start_det, stop_det;

   assign scl_rise  = scl_f & ~scl_p;
   assign scl_fall  = ~scl_f & scl_p;
   // SCL must be high both before and after the SDA transition
   assign start_det = scl_f & scl_p & sda_p & ~sda_f;
   assign stop_det  = scl_f & scl_p & ~sda_p & sda_f;

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   logic [7:0] shift;       // received bits, MSB first
   logic [7:0] tx;          // byte being shifted out in RDATA
   logic [3:0] bit_cnt;
   logic       ack_phase;   // in ACK states: 9th bit in progress
   logic       rw;
   logic [7:0] pointer;
   logic       sda_drv;
   logic       rd_pend;     // rd_data is valid this cycle

   logic [7:0] byte_in;
   logic       addr_match;
   logic [7:0] ptr_after;

   assign byte_in    = {shift[6:0], sda_f};
   assign addr_match = (byte_in[7:1] == DEV_ADDR);

`ifdef I2C_TGT_AUTOINC_EN
   assign ptr_after = pointer + 8'd1;
`else
   assign ptr_after = pointer;
`endif

   // Releasing on STOP must not wait for the register update
   assign sda_oe = sda_drv & ~stop_det;

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state;
      if (stop_det) begin
         state_next = IDLE;
      end else if (start_det) begin
         state_next = ADDR;
      end else begin
         case (state)
            ADDR: begin
               if (scl_rise && bit_cnt == 4'd7)
                  state_next = addr_match ? ADDR_ACK : IDLE;
            end
            ADDR_ACK: begin
               if (scl_fall && ack_phase)
                  state_next = rw ? RDATA : PTR;
            end
            PTR: begin
               if (scl_rise && bit_cnt == 4'd7)
                  state_next = PTR_ACK;
            end
            PTR_ACK: begin
               if (scl_fall && ack_phase)
                  state_next = WDATA;
            end
            WDATA: begin
               if (scl_rise && bit_cnt == 4'd7)
                  state_next = WDATA_ACK;
            end
            WDATA_ACK: begin
               if (scl_fall && ack_phase)
                  state_next = WDATA;
            end
            RDATA: begin
               if (scl_fall && bit_cnt == 4'd8)
                  state_next = RDATA_MACK;
            end
            RDATA_MACK: begin
               // master NACK ends the read; bus is left alone until STOP/START
               if (scl_rise && sda_f)
                  state_next = IDLE;
               else if (scl_fall && ack_phase)
                  state_next = RDATA;
            end
            default: state_next = state;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // State register and datapath
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         shift     <= 8'h00;
         tx        <= 8'h00;
         bit_cnt   <= 4'd0;
         ack_phase <= 1'b0;
         rw        <= 1'b0;
         pointer   <= 8'h00;
         sda_drv   <= 1'b0;
         busy      <= 1'b0;
         stop_evt  <= 1'b0;
         wr_en     <= 1'b0;
         wr_addr   <= 8'h00;
         wr_data   <= 8'h00;
         rd_req    <= 1'b0;
         rd_addr   <= 8'h00;
         rd_pend   <= 1'b0;
      end else begin
         state    <= state_next;
         wr_en    <= 1'b0;
         rd_req   <= 1'b0;
         stop_evt <= 1'b0;
         rd_pend  <= rd_req;
         if (rd_pend)
            tx <= rd_data;

         if (stop_det) begin
            sda_drv   <= 1'b0;
            busy      <= 1'b0;
            stop_evt  <= busy;
            bit_cnt   <= 4'd0;
            ack_phase <= 1'b0;
         end else if (start_det) begin
            sda_drv   <= 1'b0;
            busy      <= 1'b0;
            bit_cnt   <= 4'd0;
            ack_phase <= 1'b0;
         end else begin
            case (state)
               ADDR, PTR, WDATA: begin
                  if (scl_rise) begin
                     shift   <= byte_in;
                     bit_cnt <= bit_cnt + 4'd1;
                     if (bit_cnt == 4'd7) begin
                        bit_cnt   <= 4'd0;
                        ack_phase <= 1'b0;
                        if (state == ADDR && addr_match) begin
                           busy <= 1'b1;
                           rw   <= byte_in[0];
                        end
                        if (state == PTR)
                           pointer <= byte_in;
                     end
                  end
               end

               ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                  // first fall opens the ACK slot, second fall closes it
                  if (scl_fall) begin
                     if (!ack_phase) begin
                        ack_phase <= 1'b1;
                        sda_drv   <= 1'b1;
                        if (state == ADDR_ACK && rw) begin
                           rd_req  <= 1'b1;
                           rd_addr <= pointer;
                        end
                     end else begin
                        ack_phase <= 1'b0;
                        bit_cnt   <= 4'd0;
                        if (state == ADDR_ACK && rw) begin
                           sda_drv <= ~tx[7];
                           tx      <= {tx[6:0], 1'b0};
                           bit_cnt <= 4'd1;
                        end else begin
                           sda_drv <= 1'b0;
                        end
                     end
                  end
                  if (scl_rise && ack_phase && state == WDATA_ACK) begin
                     wr_en   <= 1'b1;
                     wr_addr <= pointer;
                     wr_data <= shift;
                     pointer <= ptr_after;
                  end
               end

               RDATA: begin
                  // bit_cnt counts bits already placed on SDA
                  if (scl_fall) begin
                     if (bit_cnt == 4'd8) begin
                        sda_drv   <= 1'b0;
                        ack_phase <= 1'b0;
                     end else begin
                        sda_drv <= ~tx[7];
                        tx      <= {tx[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 4'd1;
                     end
                  end
               end

               RDATA_MACK: begin
                  if (scl_rise && !sda_f) begin
                     ack_phase <= 1'b1;
                     pointer   <= ptr_after;
                     rd_req    <= 1'b1;
                     rd_addr   <= ptr_after;
                  end
                  if (scl_fall && ack_phase) begin
                     ack_phase <= 1'b0;
                     sda_drv   <= ~tx[7];
                     tx        <= {tx[6:0], 1'b0};
                     bit_cnt   <= 4'd1;
                  end
               end

               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb/tb_i2c_target_regs.sv - directed bench for i2c_target_regs

module tb_i2c_target_regs;

   localparam int Q = 10;   // clocks per quarter SCL period

`ifdef I2C_TGT_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       scl_m, sda_m;
   logic       scl_in, sda_in;
   logic       sda_oe, wr_en, rd_req, busy, stop_evt;
   logic [7:0] wr_addr, wr_data, rd_addr, rd_data;

   always #5 clk = ~clk;

   // open-drain bus: either side can pull SDA low
   assign scl_in = scl_m;
   assign sda_in = sda_m & ~sda_oe;

   i2c_target_regs dut (
      .clk      (clk),
      .reset    (reset),
      .scl_in   (scl_in),
      .sda_in   (sda_in),
      .sda_oe   (sda_oe),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_req   (rd_req),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .busy     (busy),
      .stop_evt (stop_evt)
   );

   // fabric model: first read returns 0x3C, later reads 0x5D
   int         rd_n = 0;
   logic [7:0] rd_log [0:15];
   always @(posedge clk) begin
      if (reset) begin
         rd_data <= 8'h00;
      end else if (rd_req) begin
         rd_data        <= (rd_n == 0) ? 8'h3C : 8'h5D;
         rd_log[rd_n]   <= rd_addr;
         rd_n           <= rd_n + 1;
      end
   end

   // event monitors
   int         wr_n = 0, stop_n = 0, oe_n = 0, busy_n = 0;
   logic [7:0] wr_a [0:15];
   logic [7:0] wr_d [0:15];
   always @(negedge clk) begin
      if (wr_en) begin
         wr_a[wr_n] = wr_addr;
         wr_d[wr_n] = wr_data;
         wr_n       = wr_n + 1;
      end
      if (stop_evt) stop_n = stop_n + 1;
      if (sda_oe)   oe_n   = oe_n + 1;
      if (busy)     busy_n = busy_n + 1;
   end

   int n_chk = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_cond();
      sda_m = 1'b1; scl_m = 1'b1; tick(Q);
      sda_m = 1'b0; tick(Q);
      scl_m = 1'b0; tick(Q);
   endtask

   task automatic rstart_cond();
      sda_m = 1'b1; tick(Q);
      scl_m = 1'b1; tick(Q);
      sda_m = 1'b0; tick(Q);
      scl_m = 1'b0; tick(Q);
   endtask

   task automatic stop_cond();
      sda_m = 1'b0; tick(Q);
      scl_m = 1'b1; tick(Q);
      sda_m = 1'b1; tick(2 * Q);
   endtask

   task automatic send_bit(input logic b);
      sda_m = b;    tick(Q);
      scl_m = 1'b1; tick(2 * Q);
      scl_m = 1'b0; tick(Q);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--)
         send_bit(b[i]);
      sda_m = 1'b1; tick(Q);
      scl_m = 1'b1; tick(Q);
      ack = ~sda_in;
      tick(Q);
      scl_m = 1'b0; tick(Q);
   endtask

   task automatic read_byte(output logic [7:0] d, input logic nack);
      for (int i = 7; i >= 0; i--) begin
         sda_m = 1'b1; tick(Q);
         scl_m = 1'b1; tick(Q);
         d[i] = sda_in;
         tick(Q);
         scl_m = 1'b0; tick(Q);
      end
      send_bit(nack);
   endtask

   logic       a0, a1, a2, a3;
   logic [7:0] d0, d1;
   int         b_wr, b_st, b_oe, b_busy, b_rd;

   initial begin
      reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
      tick(4);

      // reset state
      check("rst_sda_oe",   32'(sda_oe),   32'd0);
      check("rst_wr_en",    32'(wr_en),    32'd0);
      check("rst_rd_req",   32'(rd_req),   32'd0);
      check("rst_busy",     32'(busy),     32'd0);
      check("rst_stop_evt", 32'(stop_evt), 32'd0);
      check("rst_wr_addr",  32'(wr_addr),  32'd0);
      check("rst_wr_data",  32'(wr_data),  32'd0);
      check("rst_rd_addr",  32'(rd_addr),  32'd0);
      reset = 1'b0;
      tick(Q);

      // single register write
      b_wr = wr_n; b_st = stop_n;
      start_cond();
      write_byte(8'h84, a0);
      check("w1_busy", 32'(busy), 32'd1);
      write_byte(8'h10, a1);
      write_byte(8'hA5, a2);
      stop_cond();
      check("w1_ack_addr", 32'(a0), 32'd1);
      check("w1_ack_ptr",  32'(a1), 32'd1);
      check("w1_ack_data", 32'(a2), 32'd1);
      check("w1_wr_count", 32'(wr_n - b_wr), 32'd1);
      check("w1_wr_addr",  32'(wr_a[b_wr]), 32'h10);
      check("w1_wr_data",  32'(wr_d[b_wr]), 32'hA5);
      check("w1_stop_evt", 32'(stop_n - b_st), 32'd1);
      check("w1_busy_end", 32'(busy), 32'd0);

      // wrong address is ignored
      b_wr = wr_n; b_st = stop_n; b_oe = oe_n; b_busy = busy_n;
      start_cond();
      write_byte(8'h86, a0);
      write_byte(8'h11, a1);
      stop_cond();
      check("na_ack",      32'(a0), 32'd0);
      check("na_oe_cyc",   32'(oe_n - b_oe), 32'd0);
      check("na_busy_cyc", 32'(busy_n - b_busy), 32'd0);
      check("na_wr_count", 32'(wr_n - b_wr), 32'd0);
      check("na_stop_evt", 32'(stop_n - b_st), 32'd0);

      // pointer write, repeated START, two-byte read
      b_st = stop_n; b_rd = rd_n;
      start_cond();
      write_byte(8'h84, a0);
      write_byte(8'h20, a1);
      rstart_cond();
      write_byte(8'h85, a2);
      read_byte(d0, 1'b0);
      read_byte(d1, 1'b1);
      stop_cond();
      check("rd_ack_addr", 32'(a0), 32'd1);
      check("rd_ack_ptr",  32'(a1), 32'd1);
      check("rd_ack_raddr", 32'(a2), 32'd1);
      check("rd_byte0",    32'(d0), 32'h3C);
      check("rd_byte1",    32'(d1), 32'h5D);
      check("rd_req_count", 32'(rd_n - b_rd), 32'd2);
      check("rd_addr0",    32'(rd_log[b_rd]), 32'h20);
      check("rd_addr1",    32'(rd_log[b_rd + 1]), AUTOINC ? 32'h21 : 32'h20);
      check("rd_stop_evt", 32'(stop_n - b_st), 32'd1);

      // burst write across the pointer wrap
      b_wr = wr_n;
      start_cond();
      write_byte(8'h84, a0);
      write_byte(8'hFE, a1);
      write_byte(8'h01, a2);
      write_byte(8'h02, a3);
      write_byte(8'h03, a3);
      stop_cond();
      check("bw_wr_count", 32'(wr_n - b_wr), 32'd3);
      check("bw_addr0", 32'(wr_a[b_wr]),     32'hFE);
      check("bw_addr1", 32'(wr_a[b_wr + 1]), AUTOINC ? 32'hFF : 32'hFE);
      check("bw_addr2", 32'(wr_a[b_wr + 2]), AUTOINC ? 32'h00 : 32'hFE);
      check("bw_data0", 32'(wr_d[b_wr]),     32'h01);
      check("bw_data2", 32'(wr_d[b_wr + 2]), 32'h03);

      // STOP after four data bits
      b_wr = wr_n; b_st = stop_n;
      start_cond();
      write_byte(8'h84, a0);
      write_byte(8'h40, a1);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      stop_cond();
      check("ms_wr_count", 32'(wr_n - b_wr), 32'd0);
      check("ms_stop_evt", 32'(stop_n - b_st), 32'd1);
      check("ms_sda_oe",   32'(sda_oe), 32'd0);
      check("ms_busy",     32'(busy), 32'd0);

      // one-clock SDA glitch with SCL high must not look like START
      b_busy = busy_n; b_oe = oe_n;
      sda_m = 1'b0; tick(1);
      sda_m = 1'b1; tick(Q);
      scl_m = 1'b0; tick(Q);
      write_byte(8'h84, a0);
      stop_cond();
      check("gl_ack",      32'(a0), 32'd0);
      check("gl_busy_cyc", 32'(busy_n - b_busy), 32'd0);
      check("gl_oe_cyc",   32'(oe_n - b_oe), 32'd0);

      // reset in the middle of a data byte
      b_wr = wr_n; b_st = stop_n;
      start_cond();
      write_byte(8'h84, a0);
      write_byte(8'h30, a1);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      reset = 1'b1; tick(2);
      reset = 1'b0; tick(1);
      check("mr_busy",    32'(busy),    32'd0);
      check("mr_sda_oe",  32'(sda_oe),  32'd0);
      check("mr_wr_data", 32'(wr_data), 32'd0);
      check("mr_wr_addr", 32'(wr_addr), 32'd0);
      check("mr_rd_addr", 32'(rd_addr), 32'd0);
      stop_cond();
      check("mr_wr_count", 32'(wr_n - b_wr), 32'd0);
      check("mr_stop_evt", 32'(stop_n - b_st), 32'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
